adder_share_arb: RTL and testbench

//  Shares one combinational WA-bit adder (sum = a + b, WA+1 bits) between NREQ requesters.

---
 rtl/adder_share_arb_pkg.sv | 19 +
 rtl/adder_share_arb_if.sv | 30 +++
 rtl/adder_share_arb_adder.sv | 13 +
 rtl/adder_share_arb_rr_pick.sv | 29 ++
 rtl/adder_share_arb.sv | 108 ++++++++++
 tb/tb_adder_share_arb.sv | 137 +++++++++++++
 6 files changed

// File: rtl/adder_share_arb_pkg.sv
// Shared types, default widths and helpers for the shared-adder arbiter.
// The state encoding doubles as the response-valid bit.
package adder_share_arb_pkg;

  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int NREQ_DEF = 4;
  localparam int WA_DEF   = 3;
  localparam int IDW_DEF  = id_width(NREQ_DEF);
  localparam int CNTW_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_e;

endpackage

// File: rtl/adder_share_arb_if.sv
// Request/response bundle between clients and the shared-adder arbiter.
// Requester i uses operand bits [i*WA +: WA] of req_a and req_b.
interface adder_share_arb_if
  import adder_share_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int WA   = WA_DEF,
  parameter int IDW  = IDW_DEF
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*WA-1:0] req_a;
  logic [NREQ*WA-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WA:0]        rsp_sum;
  logic [IDW-1:0]     rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id
  );

endinterface

// File: rtl/adder_share_arb_adder.sv
// The single WA-bit adder shared by all requesters; carry kept as the top sum bit.
// Purely combinational.
module adder_share_arb_adder #(
  parameter int WA = 3
) (
  input  logic [WA-1:0] a,
  input  logic [WA-1:0] b,
  output logic [WA:0]   c
);

  assign c = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_share_arb_rr_pick.sv
// Round-robin picker: first valid requester after last_grant, wrapping modulo NREQ.
// Combinational; last_grant itself is the nearest-last candidate.
module adder_share_arb_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  last_grant,
  output logic            any,
  output logic [IDW-1:0]  winner
);

  logic [IDW-1:0] idx;

  // Walk offsets from farthest to nearest so the closest valid one is written last.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = IDW'((int'(last_grant) + off) % NREQ);
      if (req_valid[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin share of one adder among NREQ requesters; result registered 1 cycle after accept.
// Accepts only when the response slot is empty or draining; rsp_ready low stalls all requesters.
module adder_share_arb
  import adder_share_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int WA   = WA_DEF,
  parameter int IDW  = IDW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  adder_share_arb_if.slave    bus,
  output logic [CNTW-1:0]     op_count
);

  state_e          state_q, state_d;
  logic [WA:0]     rsp_sum_q, rsp_sum_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [CNTW-1:0] op_count_q, op_count_d;

  logic            any;
  logic [IDW-1:0]  winner;
  logic            slot_free;
  logic            accept;
  logic [WA-1:0]   a_w, b_w;
  logic [WA:0]     sum_w;

  adder_share_arb_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req_valid  (bus.req_valid),
    .last_grant (last_grant_q),
    .any        (any),
    .winner     (winner)
  );

  always_comb begin
    a_w = '0;
    b_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        a_w = bus.req_a[i*WA +: WA];
        b_w = bus.req_b[i*WA +: WA];
      end
    end
  end

  adder_share_arb_adder #(
    .WA (WA)
  ) u_adder (
    .a (a_w),
    .b (b_w),
    .c (sum_w)
  );

  // Reset blocks grants so nothing is accepted while rst is high.
  assign slot_free     = (state_q == ST_IDLE) || bus.rsp_ready;
  assign accept        = any && slot_free && !rst;
  assign bus.req_ready = accept ? (NREQ'(1) << winner) : '0;

  always_comb begin
    state_d      = state_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    op_count_d   = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (!accept && bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      rsp_sum_d    = sum_w;
      rsp_id_d     = winner;
      last_grant_d = winner;
      op_count_d   = op_count_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rsp_sum_q    <= '0;
      rsp_id_q     <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
      op_count_q   <= op_count_d;
    end
  end

  assign bus.rsp_valid = (state_q == ST_FULL);
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_id    = rsp_id_q;
  assign op_count      = op_count_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb: reset, single ops, max operands, rotation, stall, mid-op reset.
module tb_adder_share_arb;
  import adder_share_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int WA   = 3;
  localparam int IDW  = 2;
  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [CNTW-1:0] op_count;
  int              n_chk = 0;
  int              n_bad = 0;

  always #5 clk = ~clk;

  adder_share_arb_if #(.NREQ(NREQ), .WA(WA), .IDW(IDW)) bus ();

  adder_share_arb #(
    .NREQ (NREQ),
    .WA   (WA),
    .IDW  (IDW),
    .CNTW (CNTW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .op_count (op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input int vld, input int sum, input int id, input int cnt);
    chk({tag, ".vld"}, 32'(bus.rsp_valid), 32'(vld));
    chk({tag, ".sum"}, 32'(bus.rsp_sum), 32'(sum));
    chk({tag, ".id"},  32'(bus.rsp_id), 32'(id));
    chk({tag, ".cnt"}, 32'(op_count), 32'(cnt));
  endtask

  int exp_id [5]  = '{0, 1, 2, 3, 0};
  int exp_sum [5] = '{1, 3, 5, 7, 1};

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // Reset held with no requests.
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rst.rdy", 32'(bus.req_ready), 32'd0);
      chk_rsp("rst", 0, 0, 0, 0);
    end
    rst = 1'b0;

    // Single requester, two back-to-back ops.
    bus.req_valid = 4'b0001;
    bus.req_a     = {3'd0, 3'd0, 3'd0, 3'd0};
    bus.req_b     = {3'd0, 3'd0, 3'd0, 3'd3};
    #1 chk("single.rdy", 32'(bus.req_ready), 32'b0001);
    tick();
    chk_rsp("single0", 1, 3, 0, 1);
    bus.req_a = {3'd0, 3'd0, 3'd0, 3'd2};
    tick();
    chk_rsp("single1", 1, 5, 0, 2);
    bus.req_valid = '0;
    #1 chk("idle.rdy", 32'(bus.req_ready), 32'd0);
    tick();
    chk_rsp("drain", 0, 5, 0, 2);

    // Max operands on requester 3: no truncation of the carry.
    bus.req_valid = 4'b1000;
    bus.req_a     = {3'd7, 3'd0, 3'd0, 3'd0};
    bus.req_b     = {3'd7, 3'd0, 3'd0, 3'd0};
    #1 chk("max.rdy", 32'(bus.req_ready), 32'b1000);
    tick();
    chk_rsp("max", 1, 14, 3, 3);
    bus.req_valid = '0;
    tick();
    chk("max.drain", 32'(bus.rsp_valid), 32'd0);

    // All four held valid: round-robin from 0, one result per cycle.
    bus.req_a     = {3'd3, 3'd2, 3'd1, 3'd0};
    bus.req_b     = {3'd4, 3'd3, 3'd2, 3'd1};
    bus.req_valid = 4'b1111;
    #1 chk("rr.rdy", 32'(bus.req_ready), 32'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_rsp($sformatf("rr%0d", k), 1, exp_sum[k], exp_id[k], 4 + k);
    end

    // Requester 1 next with sum 5, then stall the consumer for 3 cycles.
    bus.req_a = {3'd3, 3'd4, 3'd2, 3'd0};
    bus.req_b = {3'd4, 3'd2, 3'd3, 3'd1};
    tick();
    chk_rsp("pend", 1, 5, 1, 9);
    bus.rsp_ready = 1'b0;
    #1 chk("stall.rdy", 32'(bus.req_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_rsp($sformatf("stall%0d", k), 1, 5, 1, 9);
      chk($sformatf("stall%0d.rdy", k), 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    #1 chk("release.rdy", 32'(bus.req_ready), 32'b0100);
    tick();
    chk_rsp("release", 1, 6, 2, 10);

    // Reset while a response is pending.
    rst = 1'b1;
    #1 chk("midrst.rdy", 32'(bus.req_ready), 32'd0);
    tick();
    chk_rsp("midrst", 0, 0, 0, 0);
    rst = 1'b0;
    #1 chk("after.rdy", 32'(bus.req_ready), 32'b0001);
    tick();
    chk_rsp("after", 1, 1, 0, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
